// File: rtl/fetch_sequencer_if.sv
// Fetch front-end bus: run/stall/redirect controls in, BRAM fetch and
// PC/valid pair out. The sequencer is the slave side.
interface fetch_sequencer_if #(
  parameter int PC_WIDTH  = 32,
  parameter int CNT_WIDTH = 16
);
  logic                 work_ena;
  logic                 stall;
  logic                 pc_jump;
  logic [PC_WIDTH-1:0]  pc_target;
  logic [PC_WIDTH-1:0]  bram_addr;
  logic                 bram_ren;
  logic [PC_WIDTH-1:0]  if_pc;
  logic                 if_valid;
  logic [1:0]           state_o;
  logic [CNT_WIDTH-1:0] squash_cnt;

  modport master (
    output work_ena, stall, pc_jump, pc_target,
    input  bram_addr, bram_ren, if_pc, if_valid, state_o, squash_cnt
  );

  modport slave (
    input  work_ena, stall, pc_jump, pc_target,
    output bram_addr, bram_ren, if_pc, if_valid, state_o, squash_cnt
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, drives a 1-cycle-latency BRAM
// and emits if_pc/if_valid aligned with the BRAM data output.
module fetch_sequencer #(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  PC_STEP   = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst,
  fetch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  state_t               state_q, state_d;
  logic [PC_WIDTH-1:0]  pc_q, pc_d;
  logic [PC_WIDTH-1:0]  if_pc_q, if_pc_d;
  logic                 if_valid_q, if_valid_d;
  logic [CNT_WIDTH-1:0] squash_q, squash_d;
  logic                 ren;

  // A fetch is issued whenever the front end is live and either not held
  // or being redirected (the redirect fetch is issued then squashed).
  assign ren = (state_q != IDLE) && (!bus.stall || bus.pc_jump);

  assign bus.bram_addr  = pc_q;
  assign bus.bram_ren   = ren;
  assign bus.if_pc      = if_pc_q;
  assign bus.if_valid   = if_valid_q;
  assign bus.state_o    = state_q;
  assign bus.squash_cnt = squash_q;

  // State/PC register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
      squash_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
      squash_q   <= squash_d;
    end
  end

  // Next state: park > redirect > hold > advance; encoding 3 falls to IDLE.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    squash_d   = squash_q;
    if (!bus.work_ena) begin
      state_d    = IDLE;
      pc_d       = RESET_PC;
      if_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
        end
        RUN, STALL: begin
          if (bus.pc_jump) begin
            pc_d       = bus.pc_target;
            if_pc_d    = pc_q;
            if_valid_d = 1'b0;
            state_d    = bus.stall ? STALL : RUN;
            if ((if_valid_q || ren) && (squash_q != '1))
              squash_d = squash_q + 1'b1;
          end else if (bus.stall) begin
            state_d = STALL;
          end else begin
            pc_d       = pc_q + STEP;
            if_pc_d    = pc_q;
            if_valid_d = 1'b1;
            state_d    = RUN;
          end
        end
        default: begin
          state_d    = IDLE;
          pc_d       = RESET_PC;
          if_valid_d = 1'b0;
        end
      endcase
    end
  end

endmodule
